fixed_point_alu_accel_bridge: RTL

- Parametrised successor to the single-word ALU accelerator adapter. Bridges the accelerator register-style write/read port to one fixed_point_alu instance.
- Operands and results of any width are carried as multiple ACCEL_DATA_WIDTH beats, most-significant beat first.
- Results are buffered in a small result FIFO, so the host can queue further commands before draining earlier results.

---
 rtl/fixed_point_alu_pkg.sv | 27 ++
 rtl/fixed_point_alu_accel_bridge_result_fifo.sv | 55 +++++
 rtl/fixed_point_alu_accel_bridge.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fixed_point_alu_pkg.sv
// Shared types and constants for the fixed-point ALU accelerator bridge.
// Holds the command FSM encoding, opcode values and the error sentinel.
package fixed_point_alu_pkg;

  typedef enum logic [2:0] {
    ST_READ_OP   = 3'd0,
    ST_READ_A    = 3'd1,
    ST_READ_B    = 3'd2,
    ST_WAIT_SLOT = 3'd3,
    ST_ALU_START = 3'd4,
    ST_WORK      = 3'd5
  } state_t;

  localparam logic [2:0] ALU_OP_ADD = 3'd0;
  localparam logic [2:0] ALU_OP_SUB = 3'd1;
  localparam logic [2:0] ALU_OP_MUL = 3'd2;
  localparam logic [2:0] ALU_OP_DIV = 3'd3;
  localparam logic [2:0] ALU_OP_NEG = 3'd4;

  // Truncated to the number width where used.
  localparam logic [63:0] ERR_SENTINEL = '1;

  function automatic int beats_for(input int nw, input int dw);
    return (nw + dw - 1) / dw;
  endfunction

endpackage

// File: rtl/fixed_point_alu_accel_bridge_result_fifo.sv
// Synchronous result FIFO with level output; power-of-two depth.
// Pointers wrap naturally; push while full is accepted only with a pop.
module result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/fixed_point_alu_accel_bridge.sv
// Beat-serial accelerator port to fixed_point_alu bridge with result FIFO.
// Optional macro FIXED_POINT_ALU_BRIDGE_OPCHECK_EN adds invalid-opcode trap.
module fixed_point_alu_accel_bridge
  import fixed_point_alu_pkg::*;
#(
  parameter int INTEGER_PART_WIDTH    = 8,
  parameter int FRACTIONAL_PART_WIDTH = 8,
  parameter int ACCEL_DATA_WIDTH      = 8,
  parameter int RESULT_FIFO_DEPTH     = 4,
  parameter int ALU_OP_COUNT          = 5,
  localparam int NUMBER_WIDTH =
    INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        accel_can_read,
  output logic                        accel_can_write,
  input  logic                        accel_read_enable,
  input  logic                        accel_write_enable,
  output logic [ACCEL_DATA_WIDTH-1:0] accel_read_data,
  input  logic [ACCEL_DATA_WIDTH-1:0] accel_write_data,
  output logic                        alu_start,
  input  logic                        alu_done,
  output logic [2:0]                  alu_op,
  output logic [NUMBER_WIDTH-1:0]     alu_a,
  output logic [NUMBER_WIDTH-1:0]     alu_b,
  input  logic [NUMBER_WIDTH-1:0]     alu_result,
  output logic [$clog2(RESULT_FIFO_DEPTH):0] fifo_level
`ifdef FIXED_POINT_ALU_BRIDGE_OPCHECK_EN
  ,
  output logic                        err_invalid_op
`endif
);

  localparam int NW    = NUMBER_WIDTH;
  localparam int DW    = ACCEL_DATA_WIDTH;
  localparam int BEATS = beats_for(NW, DW);
  localparam int PW    = BEATS * DW;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t           state;
  logic [CW-1:0]    beat_cnt;
  logic             beat_last;
  logic             wr_acc;
  logic [NW+DW-1:0] a_shift;
  logic [NW+DW-1:0] b_shift;
  logic             op_check_en;
  logic             bad_op;
  logic             slot_free;
  logic             trap;

  logic             fifo_push;
  logic [NW-1:0]    fifo_data;
  logic             fifo_pop;
  logic [NW-1:0]    fifo_head;
  logic             fifo_full;
  logic             fifo_empty;

  logic [CW-1:0]    rd_idx;
  logic             rd_last;
  logic             rd_acc;
  logic signed [NW-1:0] head_s;
  logic [PW-1:0]    padded;
  logic [PW-1:0]    rd_shift;

`ifdef FIXED_POINT_ALU_BRIDGE_OPCHECK_EN
  assign op_check_en = 1'b1;
`else
  assign op_check_en = 1'b0;
`endif

  assign accel_can_write = (state == ST_READ_OP) ||
                           (state == ST_READ_A)  ||
                           (state == ST_READ_B);
  assign wr_acc    = accel_can_write && accel_write_enable;
  assign beat_last = (beat_cnt == CW'(BEATS - 1));
  // Excess high bits of the first beat fall off the top here.
  assign a_shift   = {alu_a, accel_write_data};
  assign b_shift   = {alu_b, accel_write_data};
  assign alu_start = (state == ST_ALU_START);

  assign bad_op    = op_check_en &&
                     (32'(alu_op) >= ALU_OP_COUNT);
  assign slot_free = (state == ST_WAIT_SLOT) && !fifo_full;
  assign trap      = slot_free && bad_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_READ_OP;
      beat_cnt <= '0;
      alu_op   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
    end else begin
      unique case (state)
        ST_READ_OP: begin
          if (wr_acc) begin
            alu_op   <= accel_write_data[2:0];
            beat_cnt <= '0;
            state    <= ST_READ_A;
          end
        end
        ST_READ_A: begin
          if (wr_acc) begin
            alu_a <= a_shift[NW-1:0];
            if (beat_last) begin
              beat_cnt <= '0;
              state    <= ST_READ_B;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
        ST_READ_B: begin
          if (wr_acc) begin
            alu_b <= b_shift[NW-1:0];
            if (beat_last) begin
              beat_cnt <= '0;
              state    <= ST_WAIT_SLOT;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
        ST_WAIT_SLOT: begin
          if (slot_free) begin
            state <= bad_op ? ST_READ_OP : ST_ALU_START;
          end
        end
        ST_ALU_START: state <= ST_WORK;
        ST_WORK: begin
          if (alu_done) state <= ST_READ_OP;
        end
        default: state <= ST_READ_OP;
      endcase
    end
  end

`ifdef FIXED_POINT_ALU_BRIDGE_OPCHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_invalid_op <= 1'b0;
    end else if (trap) begin
      err_invalid_op <= 1'b1;
    end
  end
`endif

  assign fifo_push = ((state == ST_WORK) && alu_done) || trap;
  assign fifo_data = (state == ST_WORK) ? alu_result
                                        : ERR_SENTINEL[NW-1:0];

  result_fifo #(
    .WIDTH (NW),
    .DEPTH (RESULT_FIFO_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (fifo_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign accel_can_read = !fifo_empty;
  assign rd_acc   = accel_read_enable && !fifo_empty;
  assign rd_last  = (rd_idx == CW'(BEATS - 1));
  assign fifo_pop = rd_acc && rd_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx <= '0;
    end else if (rd_acc) begin
      rd_idx <= rd_last ? '0 : rd_idx + CW'(1);
    end
  end

  // Pad to whole beats by sign extension; beat 0 is the MS beat.
  assign head_s = fifo_head;
  assign padded = PW'(head_s);

  always_comb begin
    rd_shift = padded >> (DW * (BEATS - 1 - int'(rd_idx)));
  end

  assign accel_read_data = rd_shift[DW-1:0];

endmodule
